// File: rtl/stream_fifo_pkg.sv
// ============================================================================
//  Module      : stream_fifo_pkg
//  Description : Shared sizing helpers, parameter checks and status type
//                for stream_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_fifo_pkg;

   localparam int MIN_DEPTH    = 4;
   localparam int STATUS_CNT_W = 32;

   typedef struct packed {
      logic [STATUS_CNT_W-1:0] count;
      logic                    almost_full;
      logic                    almost_empty;
   } fifo_status_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit depth_ok(input int depth);
      return is_pow2(depth) && (depth >= MIN_DEPTH);
   endfunction

   function automatic bit afull_ok(input int th, input int depth);
      return (th >= 1) && (th <= depth);
   endfunction

   function automatic bit aempty_ok(input int th, input int depth);
      return (th >= 0) && (th <= depth - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo_dp_ram.sv
// ============================================================================
//  Module      : fifo_dp_ram
//  Description : Simple dual-port RAM, one write port and one read port with
//                a one-cycle registered, enable-gated read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_dp_ram #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 256,
   localparam int c_ADDR_W   = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [c_ADDR_W-1:0]   i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [c_ADDR_W-1:0]   i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // No reset on array or read register so the tools can map both into block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/stream_fifo.sv
// ============================================================================
//  Module      : stream_fifo
//  Description : Valid/ready synchronous FIFO with registered show-ahead
//                output, fill level, almost-full/empty flags and flush.
//                Optional high-water mark enabled by STREAM_FIFO_HWM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 256,
   parameter  int AFULL_TH   = 192,
   parameter  int AEMPTY_TH  = 16,
   localparam int CNT_W      = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  clear_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [CNT_W-1:0]      hwm_o
);

   localparam int                c_ADDR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]  c_DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  c_AFULL     = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0]  c_AEMPTY    = CNT_W'(AEMPTY_TH);
   localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
   localparam logic [c_ADDR_W:0] c_PTR_ONE   = (c_ADDR_W + 1)'(1);

   if (!depth_ok(DEPTH)) begin : g_chk_depth
      $error("stream_fifo: DEPTH must be a power of two and at least 4");
   end
   if (!afull_ok(AFULL_TH, DEPTH)) begin : g_chk_afull
      $error("stream_fifo: AFULL_TH out of range 1..DEPTH");
   end
   if (!aempty_ok(AEMPTY_TH, DEPTH)) begin : g_chk_aempty
      $error("stream_fifo: AEMPTY_TH out of range 0..DEPTH-1");
   end

   logic [c_ADDR_W:0]     r_wr_ptr;
   logic [c_ADDR_W:0]     r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_wr_ready;
   logic                  r_rd_valid;

   logic [CNT_W-1:0]      w_count_nxt;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_ram_nempty;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_ram_q;

   assign w_push       = wr_valid_i & r_wr_ready & ~clear_i;
   assign w_pop        = r_rd_valid & rd_ready_i & ~clear_i;
   assign w_ram_nempty = (r_wr_ptr != r_rd_ptr);
   // Refill the output stage whenever it is empty or being emptied this cycle.
   assign w_load       = w_ram_nempty & (~r_rd_valid | w_pop) & ~clear_i;

   always_comb begin
      w_count_nxt = r_count;
      if (clear_i) begin
         w_count_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - c_CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wr_ready <= 1'b1;
         r_rd_valid <= 1'b0;
      end else if (clear_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wr_ready <= 1'b1;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_load) begin
            r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
            r_rd_valid <= 1'b1;
         end else if (w_pop) begin
            r_rd_valid <= 1'b0;
         end
         r_count    <= w_count_nxt;
         r_wr_ready <= (w_count_nxt < c_DEPTH_CNT);
      end
   end

   fifo_dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[c_ADDR_W-1:0]),
      .i_wdata (wr_data_i),
      .i_re    (w_load),
      .i_raddr (r_rd_ptr[c_ADDR_W-1:0]),
      .o_rdata (w_ram_q)
   );

   // The RAM read register is the output stage; masking keeps rd_data_o at 0 while idle.
   assign rd_data_o      = r_rd_valid ? w_ram_q : '0;
   assign rd_valid_o     = r_rd_valid;
   assign wr_ready_o     = r_wr_ready;
   assign count_o        = r_count;
   assign almost_full_o  = (r_count >= c_AFULL);
   assign almost_empty_o = (r_count <= c_AEMPTY);

`ifdef STREAM_FIFO_HWM_EN
   logic [CNT_W-1:0] r_hwm;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_hwm <= '0;
      end else if (clear_i) begin
         r_hwm <= '0;
      end else if (w_count_nxt > r_hwm) begin
         r_hwm <= w_count_nxt;
      end
   end

   assign hwm_o = r_hwm;
`else
   assign hwm_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_fifo.sv
// ============================================================================
//  Module      : tb_stream_fifo
//  Description : Scoreboard bench for stream_fifo (DEPTH 256, 8-bit data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_fifo;
   import stream_fifo_pkg::*;

`ifdef STREAM_FIFO_HWM_EN
   localparam int c_HWM_ON = 1;
`else
   localparam int c_HWM_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       nreset;
   logic       clear_i;
   logic       wr_valid_i;
   logic       wr_ready_o;
   logic [7:0] wr_data_i;
   logic       rd_valid_o;
   logic       rd_ready_i;
   logic [7:0] rd_data_o;
   logic [8:0] count_o;
   logic       almost_full_o;
   logic       almost_empty_o;
   logic [8:0] hwm_o;

   fifo_status_t st;
   assign st = '{count: 32'(count_o), almost_full: almost_full_o, almost_empty: almost_empty_o};

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_rx     = 0;
   logic       last_acc;
   logic [7:0] exp_q[$];

   stream_fifo dut (
      .clk            (clk),
      .nreset         (nreset),
      .clear_i        (clear_i),
      .wr_valid_i     (wr_valid_i),
      .wr_ready_o     (wr_ready_o),
      .wr_data_i      (wr_data_i),
      .rd_valid_o     (rd_valid_o),
      .rd_ready_i     (rd_ready_i),
      .rd_data_o      (rd_data_o),
      .count_o        (count_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .hwm_o          (hwm_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; a write is expected
   // whenever it is offered while wr_ready_o is high.
   task automatic drive(input logic v, input logic [7:0] d, input logic rr, input logic clr);
      wr_valid_i = v;
      wr_data_i  = d;
      rd_ready_i = rr;
      clear_i    = clr;
      last_acc   = 1'b0;
      if (clr) begin
         exp_q.delete();
      end else if (v && wr_ready_o) begin
         exp_q.push_back(d);
         last_acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int bound);
      int n = 0;
      while (count_o != 9'd0 && n < bound) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         n++;
      end
      chk({name, "_count0"}, 32'(count_o), 32'd0);
      chk({name, "_valid0"}, 32'(rd_valid_o), 32'd0);
   endtask

   // Monitor: mid-cycle, the head word must match the scoreboard front.
   always @(negedge clk) begin
      if (nreset && !clear_i && rd_valid_o) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got %0h want none", rd_data_o);
         end else begin
            chk("rd_data", 32'(rd_data_o), 32'(exp_q[0]));
            if (rd_ready_i) begin
               void'(exp_q.pop_front());
               n_rx++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sent;
      int cyc;
      int rx0;

      nreset     = 1'b0;
      clear_i    = 1'b0;
      wr_valid_i = 1'b0;
      wr_data_i  = 8'h00;
      rd_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;

      // Reset values
      chk("rst_count",  st.count, 32'd0);
      chk("rst_wready", 32'(wr_ready_o), 32'd1);
      chk("rst_rvalid", 32'(rd_valid_o), 32'd0);
      chk("rst_rdata",  32'(rd_data_o), 32'd0);
      chk("rst_aempty", 32'(st.almost_empty), 32'd1);
      chk("rst_afull",  32'(st.almost_full), 32'd0);
      chk("rst_hwm",    32'(hwm_o), 32'd0);

      // 1: single word latency
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("t1_valid_n",  32'(rd_valid_o), 32'd0);
      chk("t1_count",    st.count, 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t1_valid_n1", 32'(rd_valid_o), 32'd1);
      chk("t1_data",     32'(rd_data_o), 32'hA5);
      chk("t1_aempty",   32'(st.almost_empty), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_popped",   st.count, 32'd0);

      // 2: fill to full with no reads
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 15)  chk("t2_aempty_16", 32'(st.almost_empty), 32'd1);
         if (i == 16)  chk("t2_aempty_17", 32'(st.almost_empty), 32'd0);
         if (i == 190) chk("t2_afull_191", 32'(st.almost_full), 32'd0);
         if (i == 191) chk("t2_afull_192", 32'(st.almost_full), 32'd1);
      end
      chk("t2_wready", 32'(wr_ready_o), 32'd0);
      chk("t2_count",  st.count, 32'd256);
      chk("t2_afull",  32'(st.almost_full), 32'd1);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("t2_ignored", st.count, 32'd256);
      chk("t2_head",    32'(rd_data_o), 32'd0);

      // 3: full with simultaneous write and read requests
      drive(1'b1, 8'hC3, 1'b1, 1'b0);
      chk("t3_refused",  32'(last_acc), 32'd0);
      chk("t3_wready",   32'(wr_ready_o), 32'd1);
      chk("t3_count255", st.count, 32'd255);
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 8'(k * 3 + 1), 1'b1, 1'b0);
         if (k == 0) chk("t3_first_acc", 32'(last_acc), 32'd1);
      end
      chk("t3_steady", st.count, 32'd255);
      drain("t3", 400);

      // 4: 1000 words with random read stalls, crossing pointer wrap
      rx0  = n_rx;
      sent = 0;
      cyc  = 0;
      while (sent < 1000 && cyc < 5000) begin
         drive(1'b1, 8'(sent), ($urandom_range(0, 3) != 0), 1'b0);
         if (last_acc) sent++;
         cyc++;
      end
      chk("t4_sent", 32'(sent), 32'd1000);
      drain("t4", 2000);
      chk("t4_received", 32'(n_rx - rx0), 32'd1000);

      // 5: flush with 10 words held, colliding with a write and a read
      for (int k = 0; k < 10; k++) drive(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t5_count10", st.count, 32'd10);
      drive(1'b1, 8'h77, 1'b1, 1'b1);
      chk("t5_count",  st.count, 32'd0);
      chk("t5_valid",  32'(rd_valid_o), 32'd0);
      chk("t5_wready", 32'(wr_ready_o), 32'd1);
      chk("t5_hwm",    32'(hwm_o), 32'd0);
      repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t5_still_empty", 32'(rd_valid_o), 32'd0);

      // 6: high-water mark
      for (int k = 0; k < 37; k++) drive(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
      chk("t6_count37", st.count, 32'd37);
      drain("t6", 100);
      chk("t6_hwm", 32'(hwm_o), (c_HWM_ON != 0) ? 32'd37 : 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t6_hwm_clr", 32'(hwm_o), 32'd0);

      // Asynchronous reset in the middle of a transfer
      for (int k = 0; k < 5; k++) drive(1'b1, 8'h90 + 8'(k), 1'b1, 1'b0);
      #3;
      nreset = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_count",  st.count, 32'd0);
      chk("arst_valid",  32'(rd_valid_o), 32'd0);
      chk("arst_wready", 32'(wr_ready_o), 32'd1);
      chk("arst_rdata",  32'(rd_data_o), 32'd0);
      wr_valid_i = 1'b0;
      rd_ready_i = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_release", st.count, 32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
